// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the pipeline requesters (IF, MEM), the arbiter and the memory wrapper.
// The arbiter connects through the slave modport; the pipeline/memory side uses master.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic [DATA_WIDTH-1:0] if_rdata_o;
    logic                  if_ack_o;

    logic                  mem_req_i;
    logic                  mem_we_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [DATA_WIDTH-1:0] mem_wdata_i;
    logic [MASK_WIDTH-1:0] mem_wmask_i;
    logic [DATA_WIDTH-1:0] mem_rdata_o;
    logic                  mem_ack_o;

    logic                  ram_valid_o;
    logic                  ram_ready_i;
    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [MASK_WIDTH-1:0] ram_wmask_o;
    logic                  ram_rvalid_i;
    logic [DATA_WIDTH-1:0] ram_rdata_i;

    logic                  busy_o;
    logic                  owner_o;
    logic                  err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ack_o,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
        output mem_rdata_o, mem_ack_o,
        output ram_valid_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wmask_o,
        input  ram_ready_i, ram_rvalid_i, ram_rdata_i,
        output busy_o, owner_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ack_o,
        output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
        input  mem_rdata_o, mem_ack_o,
        input  ram_valid_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wmask_o,
        output ram_ready_i, ram_rvalid_i, ram_rdata_i,
        input  busy_o, owner_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IF and MEM, MEM-priority with streak cap.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MAX_MEM_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

    if (MAX_MEM_STREAK < 1 || MAX_MEM_STREAK > 15 || TIMEOUT_CYCLES < 1 || (DATA_WIDTH % 8) != 0) begin : g_param_check
        $error("mem_port_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

    state_t                state;
    logic [3:0]            streak;
    logic                  owner;
    logic                  busy;
    logic                  ram_valid;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [MASK_WIDTH-1:0] ram_wmask;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  if_ack;
    logic                  mem_ack;

    logic                  grant_mem;
    logic                  rsp_done;
    logic [DATA_WIDTH-1:0] rsp_data;

    // MEM wins ties until it has taken MAX_MEM_STREAK grants in a row
    assign grant_mem = bus.mem_req_i && (!bus.if_req_i || streak != 4'(MAX_MEM_STREAK));

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_WIDTH-1:0] to_cnt;
    logic                err;
    logic                timed_out;

    assign timed_out = (to_cnt >= TO_WIDTH'(TIMEOUT_CYCLES - 1)) &&
                       ((state == ST_REQ && !bus.ram_ready_i) || (state == ST_WAIT && !bus.ram_rvalid_i));

    always_comb begin
        rsp_done = ((state == ST_WAIT) && bus.ram_rvalid_i) || timed_out;
        rsp_data = timed_out ? '0 : bus.ram_rdata_i;
    end
`else
    always_comb begin
        rsp_done = (state == ST_WAIT) && bus.ram_rvalid_i;
        rsp_data = bus.ram_rdata_i;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            streak    <= '0;
            owner     <= 1'b0;
            busy      <= 1'b0;
            ram_valid <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wmask <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            to_cnt    <= '0;
            err       <= 1'b0;
`endif
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err <= timed_out;
            if (state == ST_REQ || state == ST_WAIT) to_cnt <= to_cnt + 1'b1;
            else                                     to_cnt <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (bus.mem_req_i || bus.if_req_i) begin
                        state     <= ST_REQ;
                        busy      <= 1'b1;
                        ram_valid <= 1'b1;
                        owner     <= grant_mem;
                        if (grant_mem) begin
                            ram_we    <= bus.mem_we_i;
                            ram_addr  <= bus.mem_addr_i;
                            ram_wdata <= bus.mem_wdata_i;
                            ram_wmask <= bus.mem_wmask_i;
                            if (streak != 4'(MAX_MEM_STREAK)) streak <= streak + 4'd1;
                        end else begin
                            ram_we    <= 1'b0;
                            ram_addr  <= bus.if_addr_i;
                            ram_wdata <= '0;
                            ram_wmask <= '0;
                            streak    <= '0;
                        end
                    end
                    if (!bus.mem_req_i) streak <= '0;
                end
                ST_REQ: begin
                    if (bus.ram_ready_i) begin
                        state     <= ST_WAIT;
                        ram_valid <= 1'b0;
                    end
                end
                ST_WAIT: ;
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
            // Response (or watchdog expiry) overrides the per-state update above
            if (rsp_done) begin
                state     <= ST_RESP;
                ram_valid <= 1'b0;
                if (owner) begin
                    mem_rdata <= rsp_data;
                    mem_ack   <= 1'b1;
                end else begin
                    if_rdata  <= rsp_data;
                    if_ack    <= 1'b1;
                end
            end
        end
    end

    assign bus.if_rdata_o  = if_rdata;
    assign bus.if_ack_o    = if_ack;
    assign bus.mem_rdata_o = mem_rdata;
    assign bus.mem_ack_o   = mem_ack;
    assign bus.ram_valid_o = ram_valid;
    assign bus.ram_we_o    = ram_we;
    assign bus.ram_addr_o  = ram_addr;
    assign bus.ram_wdata_o = ram_wdata;
    assign bus.ram_wmask_o = ram_wmask;
    assign bus.busy_o      = busy;
    assign bus.owner_o     = owner;
`ifdef ARB_TIMEOUT_EN
    assign bus.err_o       = err;
`else
    assign bus.err_o       = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand sequences, randomized rounds vs model.
// Define ARB_TIMEOUT_EN for both files to exercise the watchdog sequence.
module tb_mem_port_arbiter;
    localparam int unsigned MAXS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_MEM_STREAK(MAXS),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // model state: streak of MEM grants and last data delivered to each requester
    int          m_streak = 0;
    logic [31:0] m_if_rd = '0;
    logic [31:0] m_mem_rd = '0;

    typedef struct {
        logic        if_req;
        logic        mem_req;
        logic        we;
        logic [31:0] if_addr;
        logic [31:0] mem_addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rd;
        int          rdy;
        int          w;
        logic        stray;
        logic        scramble;
        logic        exp_mem;
        int          exp_lat;
    } vec_t;

    vec_t tv[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {bus.if_ack_o, bus.mem_ack_o, bus.ram_valid_o, bus.ram_we_o,
                              bus.busy_o, bus.owner_o, bus.err_o}, 7'b0);
        check({tag, "_rdata"}, {bus.if_rdata_o, bus.mem_rdata_o}, 64'h0);
        check({tag, "_ram_addr"}, bus.ram_addr_o, 32'h0);
        check({tag, "_ram_wd"}, {bus.ram_wdata_o, bus.ram_wmask_o}, 36'h0);
    endtask

    function automatic logic model_mem_wins(input logic ri, input logic rm);
        if (rm && !ri) return 1'b1;
        if (ri && !rm) return 1'b0;
        return (m_streak < int'(MAXS));
    endfunction

    task automatic model_grant(input logic to_mem);
        if (to_mem) m_streak = (m_streak < int'(MAXS)) ? m_streak + 1 : int'(MAXS);
        else        m_streak = 0;
    endtask

    // Run one transaction starting in an IDLE cycle with requests already driven.
    // Acts as the memory: ready after rdy_dly extra REQ cycles, rvalid w_dly cycles into WAIT.
    task automatic run_round(input logic exp_mem, input int exp_lat, input int rdy_dly, input int w_dly,
                             input logic [31:0] rd, input logic stray, input logic scramble, input string tag);
        int cyc = 0;
        int phase = 0;
        int vcnt = 0;
        int wcnt = 0;
        int ack_cyc = -1;
        logic pay_ok = 1'b1;
        logic err_seen = 1'b0;
        logic [31:0] e_addr, e_wd;
        logic e_we;
        logic [3:0] e_mask;
        if (exp_mem) begin
            e_addr = bus.mem_addr_i; e_wd = bus.mem_wdata_i; e_we = bus.mem_we_i; e_mask = bus.mem_wmask_i;
        end else begin
            e_addr = bus.if_addr_i; e_wd = '0; e_we = 1'b0; e_mask = '0;
        end
        while (ack_cyc < 0 && cyc < 100) begin
            if (bus.ram_valid_o && (bus.ram_addr_o !== e_addr || bus.ram_wdata_o !== e_wd ||
                                    bus.ram_we_o !== e_we || bus.ram_wmask_o !== e_mask))
                pay_ok = 1'b0;
            if (phase == 1 && !bus.ram_valid_o) pay_ok = 1'b0;
            bus.ram_ready_i  = 1'b0;
            bus.ram_rvalid_i = stray && phase < 2 && ($urandom_range(0, 2) == 0);
            bus.ram_rdata_i  = $urandom;
            if (phase == 0 && bus.ram_valid_o) phase = 1;
            if (phase == 1) begin
                if (vcnt == rdy_dly) begin
                    bus.ram_ready_i = 1'b1;
                    phase = 2;
                end else vcnt++;
            end else if (phase == 2) begin
                if (wcnt == w_dly) begin
                    bus.ram_rvalid_i = 1'b1;
                    bus.ram_rdata_i  = rd;
                    phase = 3;
                end else wcnt++;
            end
            if (scramble && cyc >= 1) begin
                if (exp_mem) begin
                    bus.mem_addr_i = $urandom; bus.mem_wdata_i = $urandom;
                    bus.mem_we_i = 1'($urandom); bus.mem_wmask_i = 4'($urandom);
                end else bus.if_addr_i = $urandom;
            end
            step();
            cyc++;
            if (bus.err_o !== 1'b0) err_seen = 1'b1;
            if (bus.if_ack_o || bus.mem_ack_o) ack_cyc = cyc;
        end
        check({tag, "_ack_seen"}, ack_cyc >= 0, 1);
        check({tag, "_acks"}, {bus.if_ack_o, bus.mem_ack_o}, exp_mem ? 2'b01 : 2'b10);
        check({tag, "_latency"}, ack_cyc, exp_lat);
        check({tag, "_owner"}, bus.owner_o, exp_mem);
        check({tag, "_payload"}, pay_ok, 1'b1);
        check({tag, "_err"}, err_seen, 1'b0);
        if (exp_mem) m_mem_rd = rd;
        else         m_if_rd = rd;
        check({tag, "_if_rdata"}, bus.if_rdata_o, m_if_rd);
        check({tag, "_mem_rdata"}, bus.mem_rdata_o, m_mem_rd);
        if (exp_mem) bus.mem_req_i = 1'b0;
        else         bus.if_req_i = 1'b0;
        bus.ram_ready_i  = 1'b0;
        bus.ram_rvalid_i = 1'b0;
        step();
        check({tag, "_idle"}, {bus.busy_o, bus.if_ack_o, bus.mem_ack_o, bus.ram_valid_o}, 4'b0);
    endtask

    task automatic new_if_req(input logic [31:0] a);
        bus.if_req_i = 1'b1;
        bus.if_addr_i = a;
    endtask

    task automatic new_mem_req(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = we;
        bus.mem_addr_i = a;
        bus.mem_wdata_i = wd;
        bus.mem_wmask_i = m;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic pat[10];
        logic flag;
        int acyc;

        bus.if_req_i = 1'b0;  bus.if_addr_i = '0;
        bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0;
        bus.mem_wdata_i = '0; bus.mem_wmask_i = '0;
        bus.ram_ready_i = 1'b0; bus.ram_rvalid_i = 1'b0; bus.ram_rdata_i = '0;

        tv[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   32'h0,        4'h0,    32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 1'b0, 3};
        tv[1] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h200, 32'h12345678, 4'b0011, 32'h0,        2, 0, 1'b0, 1'b1, 1'b1, 5};
        tv[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h300, 32'h0,        4'h0,    32'hCAFE0001, 0, 1, 1'b0, 1'b0, 1'b1, 4};
        tv[3] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h304, 32'h0,        4'h0,    32'h11112222, 0, 0, 1'b1, 1'b0, 1'b1, 3};
        tv[4] = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h308, 32'hA5A5A5A5, 4'hF,    32'h0,        1, 0, 1'b0, 1'b0, 1'b1, 4};
        tv[5] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h30C, 32'h0,        4'h0,    32'h0BADF00D, 0, 0, 1'b1, 1'b1, 1'b0, 3};
        tv[6] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h30C, 32'h0,        4'h0,    32'h77778888, 1, 1, 1'b1, 1'b0, 1'b1, 5};

        // reset state, held and released
        repeat (3) step();
        check_all_zero("reset_hold");
        rst = 1'b0;
        step();
        check_all_zero("reset_rel");

        // directed vectors (streak progression 1,2,3,4 then IF wins)
        for (int i = 0; i < 7; i++) begin
            bus.if_req_i = tv[i].if_req;
            if (tv[i].if_req) bus.if_addr_i = tv[i].if_addr;
            bus.mem_req_i = tv[i].mem_req;
            if (tv[i].mem_req) new_mem_req(tv[i].we, tv[i].mem_addr, tv[i].wdata, tv[i].wmask);
            run_round(tv[i].exp_mem, tv[i].exp_lat, tv[i].rdy, tv[i].w, tv[i].rd,
                      tv[i].stray, tv[i].scramble, $sformatf("vec%0d", i));
        end

        // idle cycle with no MEM request clears the streak, then continuous contention
        step();
        m_streak = 0;
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (!bus.if_req_i) new_if_req(32'h1000 + 32'(i * 4));
            if (!bus.mem_req_i) new_mem_req(1'b0, 32'h2000 + 32'(i * 4), 32'h0, 4'h0);
            run_round(pat[i], 3, 0, 0, 32'hC0DE0000 + 32'(i), 1'b0, 1'b0, $sformatf("cont%0d", i));
        end
        bus.mem_req_i = 1'b0;
        bus.if_req_i = 1'b0;
        step();

        // reset while waiting for the response; late response must be dropped
        new_if_req(32'h400);
        step();
        check("rstw_req_valid", bus.ram_valid_o, 1'b1);
        bus.ram_ready_i = 1'b1;
        step();
        bus.ram_ready_i = 1'b0;
        check("rstw_in_wait", {bus.busy_o, bus.ram_valid_o}, 2'b10);
        rst = 1'b1;
        #1;
        check_all_zero("rstw_async");
        bus.if_req_i = 1'b0;
        step();
        bus.ram_rvalid_i = 1'b1;
        bus.ram_rdata_i = 32'hBAD0BAD0;
        step();
        rst = 1'b0;
        flag = 1'b0;
        step();
        if (bus.if_ack_o || bus.mem_ack_o || bus.busy_o) flag = 1'b1;
        bus.ram_rvalid_i = 1'b0;
        step();
        if (bus.if_ack_o || bus.mem_ack_o || bus.busy_o) flag = 1'b1;
        check("rstw_dropped", flag, 1'b0);
        check_all_zero("rstw_after");
        m_if_rd = '0; m_mem_rd = '0; m_streak = 0;
        new_if_req(32'h500);
        run_round(1'b0, 3, 0, 0, 32'h55AA55AA, 1'b0, 1'b0, "rstw_next");

        // memory that never answers
        new_if_req(32'h600);
`ifdef ARB_TIMEOUT_EN
        acyc = -1;
        for (int c = 1; c <= 40 && acyc < 0; c++) begin
            step();
            if (bus.if_ack_o || bus.mem_ack_o) acyc = c;
        end
        check("to_latency", acyc, 9);
        check("to_resp", {bus.if_ack_o, bus.mem_ack_o, bus.err_o, bus.ram_valid_o}, 4'b1010);
        check("to_rdata", bus.if_rdata_o, 32'h0);
        check("to_mem_hold", bus.mem_rdata_o, m_mem_rd);
        m_if_rd = '0;
        bus.if_req_i = 1'b0;
        step();
        check("to_after", {bus.err_o, bus.if_ack_o, bus.busy_o}, 3'b0);
`else
        flag = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.if_ack_o || bus.mem_ack_o || bus.err_o || !bus.ram_valid_o || !bus.busy_o) flag = 1'b1;
        end
        check("stall_holds", flag, 1'b0);
        bus.ram_ready_i = 1'b1;
        step();
        bus.ram_ready_i = 1'b0;
        bus.ram_rvalid_i = 1'b1;
        bus.ram_rdata_i = 32'h60606060;
        step();
        bus.ram_rvalid_i = 1'b0;
        check("stall_resp", {bus.if_ack_o, bus.mem_ack_o, bus.err_o}, 3'b100);
        check("stall_rdata", bus.if_rdata_o, 32'h60606060);
        m_if_rd = 32'h60606060;
        bus.if_req_i = 1'b0;
        step();
        check("stall_after", {bus.if_ack_o, bus.busy_o}, 2'b0);
`endif
        m_streak = 0;

        // randomized rounds against the model
        for (int r = 0; r < 250; r++) begin
            logic wm;
            int rdy, w;
            if (!bus.if_req_i && $urandom_range(0, 9) < 6) new_if_req($urandom);
            if (!bus.mem_req_i && $urandom_range(0, 9) < 7)
                new_mem_req(1'($urandom), $urandom, $urandom, 4'($urandom));
            if (!bus.if_req_i && !bus.mem_req_i) begin
                step();
                m_streak = 0;
                check($sformatf("rnd%0d_idle", r), {bus.busy_o, bus.ram_valid_o, bus.if_ack_o, bus.mem_ack_o}, 4'b0);
                continue;
            end
            wm = model_mem_wins(bus.if_req_i, bus.mem_req_i);
            model_grant(wm);
            rdy = $urandom_range(0, 3);
            w = $urandom_range(0, 2);
            run_round(wm, 3 + rdy + w, rdy, w, $urandom, 1'($urandom), 1'($urandom), $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
